// File: rtl/jtframe_dump_ctrl_if.sv
// Dump-window controller bus: frame/download inputs and window status outputs.
interface jtframe_dump_ctrl_if #(
  parameter int unsigned CW = 32
);

  logic          VGA_VS;
  logic          led;
  logic          halt;
  logic [CW-1:0] frame_cnt;
  logic          dump_on;
  logic          dump_off;
  logic          dumping;
  logic [7:0]    win_cnt;
  logic          done;

  // Stimulus side: drives sync/download/halt, observes window status.
  modport master (
    output VGA_VS, led, halt,
    input  frame_cnt, dump_on, dump_off, dumping, win_cnt, done
  );

  // Controller side.
  modport slave (
    input  VGA_VS, led, halt,
    output frame_cnt, dump_on, dump_off, dumping, win_cnt, done
  );

endinterface

// File: rtl/jtframe_dump_ctrl.sv
// Waveform-dump window controller: counts frames on VGA_VS falling edges,
// tracks the ROM-download LED and emits one-cycle dump_on/dump_off pulses.
module jtframe_dump_ctrl #(
  parameter int unsigned MODE    = 0,
  parameter int unsigned START   = 0,
  parameter int unsigned LEN     = 0,
  parameter int unsigned GAP     = 1,
  parameter int unsigned NWIN    = 1,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned CW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_dump_ctrl_if.slave bus
);

  localparam int unsigned FW      = 32;
  localparam int unsigned WW      = 8;
  // A zero gap would let dump_off and dump_on share a cycle; treat it as one frame.
  localparam int unsigned GAP_EFF = (GAP == 0) ? 1 : GAP;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    HOLD  = 3'd2,
    DUMP  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            vs_q, led_q;
  logic            vs_fall_q, led_fall_q;
  logic [CW-1:0]   frame_cnt_q;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [FW-1:0]   gcnt_q, gcnt_d;
  logic [FW-1:0]   hcnt_q, hcnt_d;
  logic [WW-1:0]   win_cnt_q, win_cnt_d;
  logic            dump_on_q, dump_on_d;
  logic            dump_off_q, dump_off_d;
  logic            dumping_q, done_q;
  logic [WW-1:0]   win_inc_c;
  logic            last_win_c;
  logic            start_hit_c;

  // Input sampling and registered edge detection; reset preloads the samples.
  always_ff @(posedge clk) begin
    vs_q  <= bus.VGA_VS;
    led_q <= bus.led;
    if (!rst_n) begin
      vs_fall_q  <= 1'b0;
      led_fall_q <= 1'b0;
    end else begin
      vs_fall_q  <= vs_q & ~bus.VGA_VS;
      led_fall_q <= led_q & ~bus.led;
    end
  end

  // Free-running frame counter, wraps at 2^CW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (vs_fall_q) begin
      frame_cnt_q <= frame_cnt_q + CW'(1);
    end
  end

  // Helpers shared by the next-state logic.
  always_comb begin
    win_inc_c   = (win_cnt_q == {WW{1'b1}}) ? win_cnt_q : win_cnt_q + WW'(1);
    last_win_c  = (NWIN != 0) && ((FW'(win_cnt_q) + FW'(1)) == FW'(NWIN));
    start_hit_c = vs_fall_q && (frame_cnt_q == CW'(START));
  end

  // Window sequencer: next state, window counters and pulse requests.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    gcnt_d     = gcnt_q;
    hcnt_d     = hcnt_q;
    win_cnt_d  = win_cnt_q;
    dump_on_d  = 1'b0;
    dump_off_d = 1'b0;

    if (bus.halt) begin
      // Halt overrides any trigger seen in the same cycle.
      state_d = DONE;
      if (state_q == DUMP) begin
        dump_off_d = 1'b1;
        win_cnt_d  = win_inc_c;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MODE == 0) begin
            state_d   = DUMP;
            dump_on_d = 1'b1;
            fcnt_d    = '0;
          end else begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (MODE == 1) begin
            if (start_hit_c) begin
              state_d   = DUMP;
              dump_on_d = 1'b1;
              fcnt_d    = '0;
            end
          end else if (MODE == 2) begin
            // A coincident VS edge is ignored here; frame_cnt still counts it.
            if (led_fall_q) begin
              state_d = HOLD;
              hcnt_d  = FW'(HOLDOFF - 1);
            end
          end
        end
        HOLD: begin
          if (bus.led) begin
            state_d = ARMED;
          end else if (hcnt_q == '0) begin
            state_d   = DUMP;
            dump_on_d = 1'b1;
            fcnt_d    = '0;
          end else begin
            hcnt_d = hcnt_q - FW'(1);
          end
        end
        DUMP: begin
          if (vs_fall_q) begin
            fcnt_d = fcnt_q + FW'(1);
            if ((LEN != 0) && ((fcnt_q + FW'(1)) == FW'(LEN))) begin
              dump_off_d = 1'b1;
              win_cnt_d  = win_inc_c;
              gcnt_d     = '0;
              state_d    = last_win_c ? DONE : WAIT;
            end
          end
        end
        WAIT: begin
          if (vs_fall_q) begin
            if ((gcnt_q + FW'(1)) == FW'(GAP_EFF)) begin
              state_d   = DUMP;
              dump_on_d = 1'b1;
              fcnt_d    = '0;
            end else begin
              gcnt_d = gcnt_q + FW'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      gcnt_q     <= '0;
      hcnt_q     <= '0;
      win_cnt_q  <= '0;
      dump_on_q  <= 1'b0;
      dump_off_q <= 1'b0;
      dumping_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      gcnt_q     <= gcnt_d;
      hcnt_q     <= hcnt_d;
      win_cnt_q  <= win_cnt_d;
      dump_on_q  <= dump_on_d;
      dump_off_q <= dump_off_d;
      dumping_q  <= (state_d == DUMP);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.dump_on   = dump_on_q;
  assign bus.dump_off  = dump_off_q;
  assign bus.dumping   = dumping_q;
  assign bus.win_cnt   = win_cnt_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Bench for jtframe_dump_ctrl: several parameterisations share one stimulus set;
// expected pulses are queued ahead of the stimulus and popped as the DUT pulses.
module tb_jtframe_dump_ctrl;

  typedef struct packed {
    logic        on;
    logic [31:0] fc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, vs, led, halt;
  int   sel;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  jtframe_dump_ctrl_if #(.CW(32)) if0 ();
  jtframe_dump_ctrl_if #(.CW(32)) if1 ();
  jtframe_dump_ctrl_if #(.CW(32)) if2 ();
  jtframe_dump_ctrl_if #(.CW(32)) if3 ();
  jtframe_dump_ctrl_if #(.CW(4))  if4 ();

  assign if0.VGA_VS = vs;  assign if0.led = led;  assign if0.halt = halt;
  assign if1.VGA_VS = vs;  assign if1.led = led;  assign if1.halt = halt;
  assign if2.VGA_VS = vs;  assign if2.led = led;  assign if2.halt = halt;
  assign if3.VGA_VS = vs;  assign if3.led = led;  assign if3.halt = halt;
  assign if4.VGA_VS = vs;  assign if4.led = led;  assign if4.halt = halt;

  jtframe_dump_ctrl #(.MODE(0), .LEN(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  jtframe_dump_ctrl #(.MODE(1), .START(3), .LEN(2), .NWIN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  jtframe_dump_ctrl #(.MODE(2), .LEN(0), .HOLDOFF(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  jtframe_dump_ctrl #(.MODE(1), .START(0), .LEN(1), .GAP(2), .NWIN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  jtframe_dump_ctrl #(.MODE(1), .START(2), .LEN(1), .NWIN(1), .CW(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic        o_on, o_off, o_dumping, o_done;
  logic [7:0]  o_win;
  logic [31:0] o_fc;

  // Route the instance under test to the observation signals.
  always_comb begin
    o_on = 1'b0; o_off = 1'b0; o_dumping = 1'b0; o_done = 1'b0; o_win = '0; o_fc = '0;
    case (sel)
      0: begin o_on = if0.dump_on; o_off = if0.dump_off; o_dumping = if0.dumping;
               o_done = if0.done; o_win = if0.win_cnt; o_fc = if0.frame_cnt; end
      1: begin o_on = if1.dump_on; o_off = if1.dump_off; o_dumping = if1.dumping;
               o_done = if1.done; o_win = if1.win_cnt; o_fc = if1.frame_cnt; end
      2: begin o_on = if2.dump_on; o_off = if2.dump_off; o_dumping = if2.dumping;
               o_done = if2.done; o_win = if2.win_cnt; o_fc = if2.frame_cnt; end
      3: begin o_on = if3.dump_on; o_off = if3.dump_off; o_dumping = if3.dumping;
               o_done = if3.done; o_win = if3.win_cnt; o_fc = if3.frame_cnt; end
      default: begin o_on = if4.dump_on; o_off = if4.dump_off; o_dumping = if4.dumping;
               o_done = if4.done; o_win = if4.win_cnt; o_fc = 32'(if4.frame_cnt); end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock; any pulse seen is matched against the scoreboard head.
  task automatic tick();
    ev_t got, want;
    @(posedge clk);
    #1;
    if (o_on || o_off) begin
      chk("pulse_exclusive", 64'(o_on & o_off), 64'd0);
      chk("pulse_vs_dumping", 64'(o_dumping), 64'(o_on));
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'({o_on, o_off}), 64'd0);
      end else begin
        want   = exp_q.pop_front();
        got.on = o_on;
        got.fc = o_fc;
        chk("pulse_event", 64'(got), 64'(want));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_dump_on", 64'(o_on), 64'd0);
    chk("rst_dump_off", 64'(o_off), 64'd0);
    chk("rst_dumping", 64'(o_dumping), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_win_cnt", 64'(o_win), 64'd0);
    chk("rst_frame_cnt", 64'(o_fc), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_ev(input logic on, input logic [31:0] fc);
    ev_t e;
    e.on = on;
    e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic led_fall_latency(input string tag);
    int lat;
    lat = 99;
    led = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_on) begin
        lat = k;
        break;
      end
    end
    chk(tag, 64'(lat), 64'd6);
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; led = 1'b0; halt = 1'b0; sel = 0;

    // MODE 0, endless window.
    sel = 0;
    do_reset();
    push_ev(1'b1, 32'd0);
    tick();
    chk("m0_on_cycle1", 64'(o_on), 64'd1);
    for (int i = 0; i < 10; i++) begin
      vs_pulse();
      chk("m0_dumping", 64'(o_dumping), 64'd1);
    end
    chk("m0_frame_cnt", 64'(o_fc), 64'd10);
    chk("m0_win_cnt", 64'(o_win), 64'd0);
    chk("m0_done", 64'(o_done), 64'd0);
    chk("m0_drained", 64'(exp_q.size()), 64'd0);

    // MODE 1, START=3 LEN=2.
    sel = 1;
    do_reset();
    push_ev(1'b1, 32'd4);
    push_ev(1'b0, 32'd6);
    for (int i = 1; i <= 8; i++) begin
      vs_pulse();
      chk("m1_dumping", 64'(o_dumping), 64'((i >= 4) && (i < 6)));
    end
    chk("m1_win_cnt", 64'(o_win), 64'd1);
    chk("m1_done", 64'(o_done), 64'd1);
    chk("m1_frame_cnt", 64'(o_fc), 64'd8);
    chk("m1_drained", 64'(exp_q.size()), 64'd0);

    // MODE 2, HOLDOFF=4: clean download end.
    sel = 2;
    led = 1'b1;
    do_reset();
    repeat (5) tick();
    chk("m2_armed_idle", 64'(o_dumping), 64'd0);
    push_ev(1'b1, 32'd0);
    led_fall_latency("m2_latency");
    chk("m2_dumping", 64'(o_dumping), 64'd1);
    chk("m2_drained", 64'(exp_q.size()), 64'd0);

    // MODE 2: new download during hold-off aborts, next fall re-arms.
    led = 1'b1;
    do_reset();
    repeat (5) tick();
    led = 1'b0;
    tick();
    tick();
    led = 1'b1;
    repeat (10) tick();
    chk("m2_abort_dumping", 64'(o_dumping), 64'd0);
    push_ev(1'b1, 32'd0);
    led_fall_latency("m2_rearm_latency");
    chk("m2_rearm_dumping", 64'(o_dumping), 64'd1);
    chk("m2_rearm_drained", 64'(exp_q.size()), 64'd0);
    led = 1'b0;

    // MODE 1, START=0 LEN=1 GAP=2 NWIN=3.
    sel = 3;
    do_reset();
    push_ev(1'b1, 32'd1); push_ev(1'b0, 32'd2);
    push_ev(1'b1, 32'd4); push_ev(1'b0, 32'd5);
    push_ev(1'b1, 32'd7); push_ev(1'b0, 32'd8);
    for (int i = 1; i <= 10; i++) begin
      vs_pulse();
      chk("mw_dumping", 64'(o_dumping), 64'((i == 1) || (i == 4) || (i == 7)));
      chk("mw_done", 64'(o_done), 64'(i >= 8));
    end
    chk("mw_win_cnt", 64'(o_win), 64'd3);
    chk("mw_drained", 64'(exp_q.size()), 64'd0);

    // Halt during an open window.
    sel = 0;
    do_reset();
    push_ev(1'b1, 32'd0);
    tick();
    vs_pulse();
    vs_pulse();
    push_ev(1'b0, 32'd2);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_off_now", 64'(o_off), 64'd1);
    chk("halt_done", 64'(o_done), 64'd1);
    chk("halt_dumping", 64'(o_dumping), 64'd0);
    chk("halt_win_cnt", 64'(o_win), 64'd1);
    repeat (3) vs_pulse();
    chk("halt_stays_done", 64'(o_done), 64'd1);
    chk("halt_no_reopen", 64'(o_dumping), 64'd0);
    chk("halt_frame_cnt", 64'(o_fc), 64'd5);
    chk("halt_drained", 64'(exp_q.size()), 64'd0);

    // CW=4 wrap, START=2 fires once.
    sel = 4;
    do_reset();
    push_ev(1'b1, 32'd3);
    push_ev(1'b0, 32'd4);
    for (int i = 1; i <= 20; i++) begin
      vs_pulse();
      if (i == 16) chk("cw4_wrap", 64'(o_fc), 64'd0);
    end
    chk("cw4_frame_cnt", 64'(o_fc), 64'd4);
    chk("cw4_win_cnt", 64'(o_win), 64'd1);
    chk("cw4_done", 64'(o_done), 64'd1);
    chk("cw4_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
